// File: rtl/serializador_paralelo_serie.sv
// Parallel-to-serial loader: accepts a WIDTH-bit word through a ready/load
// handshake and emits it one bit per clock, LSB first, framed by shift_valid,
// followed by a single-cycle done pulse.
module serializador_paralelo_serie #(
  parameter int WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     load,
  output logic                     ready,
  output logic                     serial_out,
  output logic                     shift_valid,
  output logic                     done,
  output logic [$clog2(WIDTH):0]   bit_count
);

  localparam int CW = $clog2(WIDTH) + 1;
  // Count value present while the final bit of the word is on serial_out.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] shifted;

  // Right shift with zero fill, so the next bit to send is always at index 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shifted[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shifted[WIDTH-1] = 1'b0;

  // State, data and count registers; reset (active low) wins over everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      shift_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: load only in IDLE, fixed WIDTH shifts, one DONE cycle.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (load) begin
          shift_next = data_in;
          count_next = '0;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_next = shifted;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_BIT) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        count_next = '0;
        state_next = S_IDLE;
      end
      default: begin
        shift_next = '0;
        count_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign ready       = (state_reg == S_IDLE);
  assign shift_valid = (state_reg == S_SHIFT);
  assign serial_out  = (state_reg == S_SHIFT) & shift_reg[0];
  assign done        = (state_reg == S_DONE);
  assign bit_count   = count_reg;

endmodule

// File: doc/serializador_paralelo_serie.md
Name: serializador_paralelo_serie

Overview:
- Parallel-to-serial loader placed directly upstream of the 4-bit serial shift register.
- It accepts a WIDTH-bit word through a ready/load handshake and emits the word one bit per clock, LSB first.
- Its serial_out drives the shift register's serial input.
- shift_valid frames the bits, and done marks the end of each word. After WIDTH valid shifts, the downstream register holds Q0=data[0] … Q3=data[3].

Parameters:
WIDTH, 4, word length in bits and number of serial shifts per word (≥2).

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising edge of clock; 0 = reset)
data_in  input  WIDTH  parallel word, sampled only on an accepted load
load  input  1  request to load data_in; accepted when load=1 and ready=1 at a rising edge
ready  output  1  1 when IDLE and able to accept a word
serial_out  output  1  current serial bit; 0 whenever shift_valid=0
shift_valid  output  1  1 while serial_out carries a valid bit; drives downstream shift/clock-enable
done  output  1  one-cycle pulse after the last bit of a word
bit_count  output  clog2(WIDTH)+1  number of bits already emitted in the current word

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, shift register=0, bit_count=0, serial_out=0, shift_valid=0, done=0, ready=1 in the cycle after reset.
- Reset has priority over every other input. Reset mid-word aborts the word immediately, with no done pulse and no further bits.
- All outputs are registered and derived from the state and the internal shift register. There are no combinational paths from inputs to outputs.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, shift_valid=0, done=0, serial_out=0.
  - If load=1 at an edge: capture data_in into the internal register, clear bit_count, go to SHIFT.
  - If load=0: stay in IDLE.
- SHIFT:
  - ready=0, shift_valid=1, serial_out=internal[0].
  - Each edge: shift the internal register right by 1 (zero fill) and increment bit_count.
  - On the edge where bit_count reaches WIDTH: go to DONE.
  - load is ignored and data_in is not sampled.
- DONE (exactly one cycle):
  - done=1, shift_valid=0, serial_out=0, ready=0, bit_count holds WIDTH.
  - Next edge: go to IDLE and clear bit_count.
- Latency, with the load accepted at edge k:
  - Cycles k+1 … k+WIDTH: serial_out = data[0] … data[WIDTH-1].
  - Cycle k+WIDTH+1: done=1.
  - Cycle k+WIDTH+2: ready=1.
  - Minimum word period is WIDTH+2 cycles.
- Back-to-back: if load is held at 1, the next word is accepted at the first edge where ready=1. There are no overlapping words.
- data_in changing after acceptance has no effect on the word in flight.
- A load pulse arriving while ready=0 is dropped, not queued.

Test Plan:
- Reset: hold reset=0 for 2 cycles with load=1 and data_in=4'hF -> ready=1, serial_out=0, shift_valid=0, done=0, bit_count=0; no word accepted while reset=0.
- Single word: load data_in=4'b1011 for one cycle from IDLE -> next 4 cycles serial_out=1,1,0,1 with shift_valid=1. Downstream register then reads Q3..Q0=1011. done=1 one cycle later, ready=1 the following cycle.
- Ignored load: issue load with data_in=4'h0 during SHIFT of word 4'hA -> output stream stays 0,1,0,1; exactly one done pulse; no extra word.
- Back-to-back: load held at 1, data_in=4'h3 then 4'hC -> bits 1,1,0,0, done, gap, then 0,0,1,1. Words start 6 cycles apart.
- Reset mid-operation: load 4'hF, assert reset=0 after 2 bits -> next cycle shift_valid=0, serial_out=0, done never pulses, ready=1 after reset released.
- Data stability: change data_in every cycle during SHIFT of 4'h6 -> serial stream stays 0,1,1,0.
